uart_tx_arbiter: RTL

- Shares the single UART transmitter among kNumReq byte-stream requesters, e.g. a debug console, telemetry and an echo path.
- Packet-oriented round-robin: a granted requester keeps the transmitter until it flags its last byte, goes idle too long, or reaches the burst limit.
- Sits between the requesters and the UART's tx_data/tx_valid/tx_ready port. Sequences one byte at a time against the UART's registered tx_ready behaviour.

---
 rtl/uart_tx_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-oriented arbiter that shares one UART transmitter among kNumReq
// byte-stream requesters, sequencing each byte against the UART's registered ready flag.
module uart_tx_arbiter #(
    parameter int unsigned kNumReq     = 4,
    parameter int unsigned kMaxBurst   = 64,
    parameter int unsigned kGapTimeout = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*kNumReq-1:0]   req_data,
    input  logic [kNumReq-1:0]     req_valid,
    input  logic [kNumReq-1:0]     req_last,
    output logic [kNumReq-1:0]     req_ready,
    output logic [kNumReq-1:0]     grant,
    output logic [7:0]             uart_tx_data,
    output logic                   uart_tx_valid,
    input  logic                   uart_tx_ready,
    output logic                   gap_timeout,
    output logic                   busy
);

    localparam int unsigned IdxW = $clog2(kNumReq);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIssue,
        StWaitBusy,
        StWaitDone
    } state_e;

    state_e              state_q, state_d;
    logic [kNumReq-1:0]  grant_q, grant_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [7:0]          burst_q, burst_d;
    logic [15:0]         gap_q, gap_d;
    logic [7:0]          data_q, data_d;
    logic                last_q, last_d;

    logic [IdxW-1:0]     arb_idx;
    logic                arb_found;
    logic [IdxW-1:0]     next_ptr;
    logic                own_valid;
    logic                own_last;
    logic [7:0]          own_data;

    // First valid requester at or after rr_ptr, wrapping modulo kNumReq.
    always_comb begin
        int unsigned     cand;
        logic [IdxW-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        arb_idx   = '0;
        arb_found = 1'b0;
        for (int unsigned k = 0; k < kNumReq; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= kNumReq) begin
                cand = cand - kNumReq;
            end
            cand_idx = IdxW'(cand);
            if (!arb_found && req_valid[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    assign next_ptr  = (idx_q == IdxW'(kNumReq - 1)) ? '0 : idx_q + IdxW'(1);
    assign own_valid = req_valid[idx_q];
    assign own_last  = req_last[idx_q];
    assign own_data  = req_data[{idx_q, 3'b000} +: 8];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        idx_d         = idx_q;
        rr_ptr_d      = rr_ptr_q;
        burst_d       = burst_q;
        gap_d         = gap_q;
        data_d        = data_q;
        last_d        = last_q;
        req_ready     = '0;
        uart_tx_valid = 1'b0;
        gap_timeout   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arb_found) begin
                    grant_d          = '0;
                    grant_d[arb_idx] = 1'b1;
                    idx_d            = arb_idx;
                    burst_d          = '0;
                    gap_d            = '0;
                    state_d          = StLoad;
                end
            end
            StLoad: begin
                req_ready = grant_q & req_valid;
                if (own_valid) begin
                    data_d  = own_data;
                    last_d  = own_last;
                    burst_d = burst_q + 8'd1;
                    gap_d   = '0;
                    state_d = StIssue;
                end else if (gap_q == 16'(kGapTimeout - 1)) begin
                    gap_timeout = 1'b1;
                    grant_d     = '0;
                    rr_ptr_d    = next_ptr;
                    gap_d       = '0;
                    state_d     = StIdle;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            StIssue: begin
                if (uart_tx_ready) begin
                    uart_tx_valid = 1'b1;
                    state_d       = StWaitBusy;
                end
            end
            StWaitBusy: begin
                // UART drops ready one edge after it takes the byte.
                if (!uart_tx_ready) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (uart_tx_ready) begin
                    if (last_q || (burst_q == 8'(kMaxBurst))) begin
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                        state_d  = StIdle;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            idx_q    <= '0;
            rr_ptr_q <= '0;
            burst_q  <= '0;
            gap_q    <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
            burst_q  <= burst_d;
            gap_q    <= gap_d;
            data_q   <= data_d;
            last_q   <= last_d;
        end
    end

    assign grant        = grant_q;
    assign uart_tx_data = data_q;
    assign busy         = (state_q != StIdle);

endmodule
